// File: rtl/bt_slot_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// bt_slot_pkg : shared types/constants for the slot scheduler          rev 1.0
// -----------------------------------------------------------------------------
package bt_slot_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    TX      = 3'd2,
    RX_SRCH = 3'd3,
    RX_PKT  = 3'd4
  } sched_state_e;

  localparam logic [9:0] RX_WIN_US_DEF = 10'd78;
  localparam logic [2:0] MAX_SLOTS_DEF = 3'd5;

  // Legal packet lengths are odd and no longer than max_slots; anything else is a 1-slot packet.
  function automatic logic [2:0] slot_len(input logic [2:0] raw, input logic [2:0] max_slots);
    logic [2:0] len;
    len = 3'd1;
    if (raw[0] && (raw <= max_slots)) len = raw;
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/slot_sched.sv
`default_nettype none
// -----------------------------------------------------------------------------
// slot_sched : per-slot TX/RX scheduler, clk_6M domain                 rev 1.0
// -----------------------------------------------------------------------------
module slot_sched
  import bt_slot_pkg::*;
#(
  parameter logic [9:0] RX_WIN_US = RX_WIN_US_DEF,
  parameter logic [2:0] MAX_SLOTS = MAX_SLOTS_DEF
) (
  input  logic        clk_6M,
  input  logic        rst,
  input  logic        p_1us,
  input  logic        tslot_p,
  input  logic        half_tslot_p,
  input  logic [27:0] BTCLK,
  input  logic [9:0]  offcounter_1us,
  input  logic        regi_conn_en,
  input  logic        regi_master,
  input  logic        tx_req,
  input  logic [2:0]  tx_slots,
  input  logic        corre_sync_p,
  input  logic        rx_hdr_valid_p,
  input  logic [2:0]  rx_pkt_slots,
  output logic        tx_en,
  output logic        tx_start_p,
  output logic        rx_en,
  output logic        hop_p,
  output logic        rx_timeout_p,
  output logic [2:0]  sched_state
);

  sched_state_e state;
  logic [2:0]   rem;

  logic nxt_even;
  logic own_next;
  logic win_close;
  logic rem_last;
  logic unused_btclk;

  // BTCLK[1:0] == 11 at the slot end means the carry lands on an even slot.
  assign nxt_even     = BTCLK[1] & BTCLK[0];
  assign own_next     = (nxt_even == regi_master);
  assign win_close    = p_1us && (offcounter_1us == RX_WIN_US);
  assign rem_last     = (rem <= 3'd1);
  assign unused_btclk = ^BTCLK[27:2];
  assign sched_state  = state;

  always_ff @(posedge clk_6M) begin
    tx_start_p   <= 1'b0;
    hop_p        <= 1'b0;
    rx_timeout_p <= 1'b0;
    if (rst || !regi_conn_en) begin
      state <= IDLE;
      rem   <= 3'd0;
      tx_en <= 1'b0;
      rx_en <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= WAIT;

        WAIT: begin
          if (tslot_p) begin
            if (regi_master && own_next && tx_req) begin
              state      <= TX;
              rem        <= slot_len(tx_slots, MAX_SLOTS);
              tx_en      <= 1'b1;
              tx_start_p <= 1'b1;
              hop_p      <= 1'b1;
            end else if (!regi_master && !own_next) begin
              state <= RX_SRCH;
              rx_en <= 1'b1;
              hop_p <= 1'b1;
            end
          end
        end

        TX: begin
          if (tslot_p) begin
            if (rem_last) begin
              rem   <= 3'd0;
              tx_en <= 1'b0;
              if (regi_master) begin
                state <= RX_SRCH;
                rx_en <= 1'b1;
                hop_p <= 1'b1;
              end else begin
                state <= WAIT;
              end
            end else begin
              rem <= rem - 3'd1;
            end
          end
        end

        RX_SRCH: begin
          // Sync outranks both window close and a coincident slot boundary.
          if (corre_sync_p) begin
            state <= RX_PKT;
            rem   <= 3'd1;
            rx_en <= 1'b1;
          end else if (rx_en && win_close) begin
            rx_en        <= 1'b0;
            rx_timeout_p <= 1'b1;
            if (regi_master) state <= WAIT;
          end else if (!rx_en && tslot_p && !regi_master && !own_next) begin
            rx_en <= 1'b1;
            hop_p <= 1'b1;
          end
        end

        RX_PKT: begin
          if (rx_hdr_valid_p) begin
            rem <= slot_len(rx_pkt_slots, MAX_SLOTS);
          end else if (tslot_p) begin
            if (rem_last) begin
              rx_en <= 1'b0;
              if (!regi_master && tx_req && own_next) begin
                state      <= TX;
                rem        <= slot_len(tx_slots, MAX_SLOTS);
                tx_en      <= 1'b1;
                tx_start_p <= 1'b1;
                hop_p      <= 1'b1;
              end else begin
                state <= WAIT;
                rem   <= 3'd0;
              end
            end else begin
              rem <= rem - 3'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_6M) begin
    if (!rst) begin
      assert (!(tx_en && rx_en));
      assert (!(tslot_p && half_tslot_p));
    end
  end

endmodule
`default_nettype wire
